// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates menu/game/message frames and scans them onto a 4-digit 7-segment display
module display_scheduler #(
  parameter int SCAN_DIV   = 27000,
  parameter int BLANK_CYC  = 270,
  parameter int MSG_FRAMES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  presente,
  input  logic [27:0] menu_disp,
  input  logic [27:0] game_disp,
  input  logic [27:0] msg_disp,
  input  logic        msg_req,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  src_sel
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(MSG_FRAMES + 1);
  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [27:0]   frame_buf, msg_buf, sel_frame, fb_nxt;
  logic [FW-1:0] fcnt;
  logic [1:0]    sel;
  logic          boundary, wrap, expire, busy_eff, lit, grant, off;
  // Source arbitration and next frame; an expiring message yields at the same boundary
  always_comb begin
    off       = presente == 3'd0 || presente > 3'd5;
    wrap      = cnt == CW'(SCAN_DIV - 1);
    boundary  = cnt == '0 && digit == 2'd0;
    expire    = msg_busy && boundary && fcnt == FW'(MSG_FRAMES);
    busy_eff  = msg_busy && !expire;
    sel       = off ? 2'd0 : busy_eff ? 2'd3 : presente == 3'd3 ? 2'd2 : 2'd1;
    sel_frame = sel == 2'd3 ? msg_buf : sel == 2'd2 ? game_disp : sel == 2'd1 ? menu_disp : '0;
    fb_nxt    = boundary ? sel_frame : frame_buf;
    lit       = cnt < CW'(SCAN_DIV - BLANK_CYC);
    grant     = !msg_busy && msg_req && presente != 3'd0;
  end
  assign msg_ack = rst_n && grant;
  // Scan counters, frame snapshot and registered digit drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      digit     <= '0;
      frame_buf <= '0;
      src_sel   <= '0;
      seg       <= '0;
      an        <= '0;
    end else begin
      cnt       <= wrap ? '0 : cnt + 1'b1;
      digit     <= wrap ? digit + 1'b1 : digit;
      frame_buf <= fb_nxt;
      src_sel   <= boundary ? sel : src_sel;
      seg       <= lit ? fb_nxt[7*digit +: 7] : '0;
      an        <= lit ? 4'b0001 << digit : '0;
    end
  end
  // Message grant, lifetime counting and release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_busy <= 1'b0;
      msg_buf  <= '0;
      fcnt     <= '0;
    end else if (grant) begin
      msg_busy <= 1'b1;
      msg_buf  <= msg_disp;
      fcnt     <= '0;
    end else if (msg_busy) begin
      msg_busy <= !(presente == 3'd0 || expire);
      fcnt     <= boundary ? fcnt + 1'b1 : fcnt;
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed vector check of frame scanning, arbitration and message lifetime
module tb_display_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  presente = 3'd1;
  logic [27:0] menu_disp = {7'h76, 7'h3F, 7'h38, 7'h77};
  logic [27:0] game_disp = {7'h06, 7'h5B, 7'h4F, 7'h66};
  logic [27:0] msg_disp = 28'h0F0F0F0;
  logic        msg_req = 1'b0;
  logic        msg_ack, msg_busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  src_sel;
  int          n_vec = 0;
  int          n_mis = 0;
  typedef struct {
    string      nm;
    int         n;
    logic [2:0] pres;
    logic       req;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] src;
    logic       ack;
    logic       busy;
  } vec_t;
  vec_t tbl[$];
  display_scheduler #(.SCAN_DIV(8), .BLANK_CYC(2), .MSG_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .presente(presente), .menu_disp(menu_disp),
    .game_disp(game_disp), .msg_disp(msg_disp), .msg_req(msg_req),
    .msg_ack(msg_ack), .msg_busy(msg_busy), .seg(seg), .an(an), .src_sel(src_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [6:0] es, input logic [3:0] ea,
                     input logic [1:0] ss, input logic ek, input logic eb);
    n_vec++;
    if ({seg, an, src_sel, msg_ack, msg_busy} !== {es, ea, ss, ek, eb}) begin
      n_mis++;
      $display("FAIL %s: got seg=%h an=%b src=%0d ack=%b busy=%b, want seg=%h an=%b src=%0d ack=%b busy=%b",
               nm, seg, an, src_sel, msg_ack, msg_busy, es, ea, ss, ek, eb);
    end
  endtask
  task automatic step(input int n);
    if (n == 0) #1;
    else repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    tbl.push_back('{"menu_d0_first",   1, 3'd1, 1'b0, 7'h77, 4'b0001, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{"menu_d0_lastlit", 5, 3'd1, 1'b0, 7'h77, 4'b0001, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{"menu_blank",      1, 3'd1, 1'b0, 7'h00, 4'b0000, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{"menu_d1",         2, 3'd1, 1'b0, 7'h38, 4'b0010, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{"game_no_tear",    8, 3'd3, 1'b0, 7'h3F, 4'b0100, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{"game_boundary",  16, 3'd3, 1'b0, 7'h66, 4'b0001, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{"game_d1",         8, 3'd3, 1'b0, 7'h4F, 4'b0010, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{"grant_ack",       0, 3'd1, 1'b1, 7'h4F, 4'b0010, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{"busy_rise",       1, 3'd1, 1'b1, 7'h4F, 4'b0010, 2'd2, 1'b0, 1'b1});
    tbl.push_back('{"msg_frame1",     23, 3'd1, 1'b0, 7'h70, 4'b0001, 2'd3, 1'b0, 1'b1});
    tbl.push_back('{"no_ack_busy",     0, 3'd1, 1'b1, 7'h70, 4'b0001, 2'd3, 1'b0, 1'b1});
    tbl.push_back('{"msg_d1",          8, 3'd1, 1'b1, 7'h61, 4'b0010, 2'd3, 1'b0, 1'b1});
    tbl.push_back('{"msg_frame3",     56, 3'd1, 1'b1, 7'h70, 4'b0001, 2'd3, 1'b0, 1'b1});
    tbl.push_back('{"msg_last_blank", 31, 3'd1, 1'b1, 7'h00, 4'b0000, 2'd3, 1'b0, 1'b1});
    tbl.push_back('{"expire_menu",     1, 3'd1, 1'b1, 7'h77, 4'b0001, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{"regrant",         1, 3'd1, 1'b1, 7'h77, 4'b0001, 2'd1, 1'b0, 1'b1});
    tbl.push_back('{"off_drop",        1, 3'd0, 1'b0, 7'h77, 4'b0001, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{"off_blank_d0",   30, 3'd0, 1'b0, 7'h00, 4'b0001, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{"off_blank_d1",    8, 3'd0, 1'b0, 7'h00, 4'b0010, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{"menu_back",      25, 3'd1, 1'b0, 7'h77, 4'b0001, 2'd1, 1'b0, 1'b0});
    tbl.push_back('{"busy_pre_rst",    1, 3'd1, 1'b1, 7'h77, 4'b0001, 2'd1, 1'b0, 1'b1});
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 7'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    foreach (tbl[i]) begin
      presente = tbl[i].pres;
      msg_req  = tbl[i].req;
      step(tbl[i].n);
      chk(tbl[i].nm, tbl[i].seg, tbl[i].an, tbl[i].src, tbl[i].ack, tbl[i].busy);
    end
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 7'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    msg_req = 1'b0;
    step(1);
    chk("restart_d0", 7'h77, 4'b0001, 2'd1, 1'b0, 1'b0);
    step(8);
    chk("restart_d1", 7'h38, 4'b0010, 2'd1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
